// File: rtl/pc_fetch.sv
// pc_fetch: program counter with IDLE/RUN/DONE sequencing, a four-entry
// writable branch-target table and a saturating retired-instruction counter.
module pc_fetch #(
    parameter int              PC_W  = 10,
    parameter logic [PC_W-1:0] TARG0 = '0,
    parameter logic [PC_W-1:0] TARG1 = '0,
    parameter logic [PC_W-1:0] TARG2 = '0,
    parameter logic [PC_W-1:0] TARG3 = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            Zero,
    input  logic [1:0]      PCTarg,
    input  logic            Ack,
    input  logic            LutWe,
    input  logic [1:0]      LutWaddr,
    input  logic [PC_W-1:0] LutWdata,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic [15:0]     InstCount
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, w_pc;
    logic [15:0]     r_cnt, w_cnt;
    logic            r_running, r_done;
    logic [PC_W-1:0] r_lut [4];
    logic            w_redir;

    assign ProgCtr   = r_pc;
    assign InstCount = r_cnt;
    assign Running   = r_running;
    assign Done      = r_done;

    always_comb begin
        w_next  = r_state;
        w_pc    = r_pc;
        w_cnt   = r_cnt;
        w_redir = Jump | (BranchEn & Zero);
        if (r_state == RUN) begin
            w_cnt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            if (Ack)
                w_next = DONE;
            else if (w_redir)
                w_pc = r_lut[PCTarg];
            else
                w_pc = r_pc + PC_W'(1);
        end else if (Start) begin
            w_next = RUN;
            w_pc   = StartAddr;
            w_cnt  = 16'd0;
        end
    end

    // Table reads above see the registered entries, so a same-cycle write
    // to the redirect entry only takes effect for later redirects.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_lut[0]  <= TARG0;
            r_lut[1]  <= TARG1;
            r_lut[2]  <= TARG2;
            r_lut[3]  <= TARG3;
        end else begin
            r_state   <= w_next;
            r_pc      <= w_pc;
            r_cnt     <= w_cnt;
            r_running <= (w_next == RUN);
            r_done    <= (w_next == DONE);
            if (LutWe)
                r_lut[LutWaddr] <= LutWdata;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed-sequence bench for pc_fetch with hand-computed expectations.
module tb_pc_fetch;
    logic        Clk = 1'b0;
    logic        Reset, Start, Jump, BranchEn, Zero, Ack, LutWe;
    logic [9:0]  StartAddr, LutWdata, ProgCtr;
    logic [1:0]  PCTarg, LutWaddr;
    logic        Running, Done;
    logic [15:0] InstCount;
    int          checks = 0;
    int          errors = 0;

    pc_fetch #(
        .PC_W(10), .TARG0(10'h100), .TARG1(10'h020), .TARG2(10'h004), .TARG3(10'h2C0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Jump(Jump), .BranchEn(BranchEn), .Zero(Zero), .PCTarg(PCTarg),
        .Ack(Ack), .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] pc, input logic [15:0] cnt,
                           input logic run, input logic dn);
        chk({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
        chk({tag, ".cnt"}, 32'(InstCount), 32'(cnt));
        chk({tag, ".run"}, 32'(Running), 32'(run));
        chk({tag, ".done"}, 32'(Done), 32'(dn));
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; Jump = 1'b0; BranchEn = 1'b0;
        Zero = 1'b0; PCTarg = '0; Ack = 1'b0; LutWe = 1'b0; LutWaddr = '0; LutWdata = '0;
        #3;
        chk_all("reset", 10'h000, 16'd0, 1'b0, 1'b0);
        #4 Reset = 1'b1;
        Jump = 1'b1; PCTarg = 2'd0;
        step;
        chk_all("idle_hold", 10'h000, 16'd0, 1'b0, 1'b0);
        Jump = 1'b0;
        Start = 1'b1; StartAddr = 10'h010;
        step;
        chk_all("start", 10'h010, 16'd0, 1'b1, 1'b0);
        Start = 1'b0;
        step; chk_all("seq1", 10'h011, 16'd1, 1'b1, 1'b0);
        step; chk_all("seq2", 10'h012, 16'd2, 1'b1, 1'b0);
        step; chk_all("seq3", 10'h013, 16'd3, 1'b1, 1'b0);
        LutWe = 1'b1; LutWaddr = 2'd2; LutWdata = 10'h155;
        step; chk_all("lutwr2", 10'h014, 16'd4, 1'b1, 1'b0);
        LutWe = 1'b0; BranchEn = 1'b1; Zero = 1'b1; PCTarg = 2'd2;
        step; chk_all("br_taken", 10'h155, 16'd5, 1'b1, 1'b0);
        Zero = 1'b0;
        step; chk_all("br_not", 10'h156, 16'd6, 1'b1, 1'b0);
        BranchEn = 1'b0; Jump = 1'b1; PCTarg = 2'd3;
        step; chk_all("jump3", 10'h2C0, 16'd7, 1'b1, 1'b0);
        Jump = 1'b0; LutWe = 1'b1; LutWaddr = 2'd0; LutWdata = 10'h3FF;
        step; chk_all("lutwr0", 10'h2C1, 16'd8, 1'b1, 1'b0);
        LutWe = 1'b0; Jump = 1'b1; PCTarg = 2'd0;
        step; chk_all("jump_top", 10'h3FF, 16'd9, 1'b1, 1'b0);
        Jump = 1'b0;
        step; chk_all("wrap", 10'h000, 16'd10, 1'b1, 1'b0);
        Jump = 1'b1;
        step; chk_all("jump_top2", 10'h3FF, 16'd11, 1'b1, 1'b0);
        Ack = 1'b1;
        step; chk_all("ack_jump", 10'h3FF, 16'd12, 1'b0, 1'b1);
        Ack = 1'b0;
        step; chk_all("done_hold", 10'h3FF, 16'd12, 1'b0, 1'b1);
        Jump = 1'b0; Start = 1'b1; StartAddr = 10'h050;
        step; chk_all("restart", 10'h050, 16'd0, 1'b1, 1'b0);
        Start = 1'b0; LutWe = 1'b1; LutWaddr = 2'd1; LutWdata = 10'h0AA;
        Jump = 1'b1; PCTarg = 2'd1;
        step; chk_all("wr_vs_jump", 10'h020, 16'd1, 1'b1, 1'b0);
        LutWe = 1'b0;
        step; chk_all("jump_new", 10'h0AA, 16'd2, 1'b1, 1'b0);
        Jump = 1'b0; Start = 1'b1; StartAddr = 10'h123;
        step; chk_all("start_in_run", 10'h0AB, 16'd3, 1'b1, 1'b0);
        Start = 1'b0;
        #2 Reset = 1'b0;
        #1 chk_all("async_rst", 10'h000, 16'd0, 1'b0, 1'b0);
        Start = 1'b1; StartAddr = 10'h200;
        @(negedge Clk);
        chk_all("rst_held", 10'h000, 16'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        step; chk_all("first_edge", 10'h200, 16'd0, 1'b1, 1'b0);
        Start = 1'b0; Jump = 1'b1;
        PCTarg = 2'd0; step; chk_all("lut0", 10'h100, 16'd1, 1'b1, 1'b0);
        PCTarg = 2'd1; step; chk_all("lut1", 10'h020, 16'd2, 1'b1, 1'b0);
        PCTarg = 2'd2; step; chk_all("lut2", 10'h004, 16'd3, 1'b1, 1'b0);
        PCTarg = 2'd3; step; chk_all("lut3", 10'h2C0, 16'd4, 1'b1, 1'b0);
        Jump = 1'b0;
        repeat (65540) @(posedge Clk);
        #1;
        chk("sat.cnt", 32'(InstCount), 32'hFFFF);
        chk("sat.run", 32'(Running), 32'd1);
        step; chk("sat_hold.cnt", 32'(InstCount), 32'hFFFF);
        Ack = 1'b1;
        step; chk("sat_ack.cnt", 32'(InstCount), 32'hFFFF);
        chk("sat_ack.done", 32'(Done), 32'd1);
        Ack = 1'b0; Start = 1'b1; StartAddr = 10'h0F0;
        step; chk_all("restart2", 10'h0F0, 16'd0, 1'b1, 1'b0);
        Start = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
